dmem_arbiter: RTL and testbench

Shares the single-port synchronous data memory between the execute unit's load/store port and a DMA/debug port. The arbiter sits between execute (`d_mem_*`) and the data SRAM. It grants one access per cycle, stalls the losing requester, and returns read data to the port that issued the read. CPU accesses have fixed priority, but a starvation counter guarantees DMA progress.

---
 rtl/dmem_arbiter.sv | 119 +++++++++++
 tb/tb_dmem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data SRAM between the execute unit's
// load/store port (cpu_*) and a DMA/debug port (dma_*). One access is granted
// per cycle. The CPU has fixed priority unless the DMA has been denied for
// STARVE_LIMIT consecutive cycles, in which case the DMA overrides for one cycle.
//
// Handshake: a request (cpu_req, dma_req) is accepted in the cycle its grant
// (~cpu_stall, dma_gnt) is high. Until it is accepted, the requester holds
// every request field stable. Read data returns one cycle after the grant,
// qualified by cpu_rvalid / dma_rvalid. Writes complete in the grant cycle
// and produce no response.
module dmem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_,
    // execute-unit port
    input  logic              cpu_en,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    // DMA / debug port
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    // SRAM port
    output logic              mem_en,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic       cpu_req;
    logic       dma_pri;
    logic       dma_win;
    logic       cpu_win;
    logic       rd_grant;
    logic       rd_pend_q;
    logic       rd_owner_q;   // 0 = CPU, 1 = DMA
    logic [3:0] starve_cnt;

    // Grant decision: DMA wins when the CPU is idle or when it has starved long enough.
    always_comb begin
        cpu_req   = cpu_en & (cpu_rd | cpu_wr);
        dma_pri   = (starve_cnt == LIMIT);
        dma_win   = dma_req & (~cpu_req | dma_pri);
        cpu_win   = cpu_req & ~dma_win;
        cpu_stall = cpu_req & ~cpu_win;
        dma_gnt   = dma_win;
    end

    // Memory mux: the winner drives the SRAM; a CPU rd+wr is treated as a write.
    always_comb begin
        mem_en    = cpu_win | dma_win;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dma_win) begin
            mem_rd    = ~dma_we;
            mem_wr    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else if (cpu_win) begin
            mem_rd    = cpu_rd & ~cpu_wr;
            mem_wr    = cpu_wr;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    assign rd_grant = mem_en & mem_rd;

    // Read tracking: remember that a read was granted last cycle and who owns it.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            rd_pend_q <= rd_grant;
            if (rd_grant) begin
                rd_owner_q <= dma_win;
            end
        end
    end

    // Starvation counter: counts consecutive denied DMA cycles, saturating at the limit.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            starve_cnt <= 4'd0;
        end else if (dma_win || !dma_req) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Read return: SRAM data steered to the owning port, zero on the other.
    always_comb begin
        cpu_rvalid = rd_pend_q & ~rd_owner_q;
        dma_rvalid = rd_pend_q & rd_owner_q;
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        dma_rdata  = dma_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by a randomized run
// checked against a cycle-level reference model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int ADDR_W       = 12;
    localparam int DATA_W       = 8;
    localparam int STARVE_LIMIT = 4;
    localparam int W            = DATA_W + 1;   // {owner, data}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_;
    always #5 clk = ~clk;

    logic              cpu_en, cpu_rd, cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall, cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              dma_req, dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt, dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;
    logic              mem_en, mem_rd, mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int n_checks = 0;
    int n_err    = 0;

    dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset_(reset_),
        .cpu_en(cpu_en), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_en(mem_en), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // ---------------- SRAM model and reference memory ----------------
    logic [DATA_W-1:0] sram    [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];

    always @(posedge clk) begin
        if (mem_en && mem_wr) sram[mem_addr] <= mem_wdata;
        if (mem_en && mem_rd) mem_rdata <= sram[mem_addr];
    end

    // scoreboard of expected read returns: {owner(1=DMA), data}
    logic [W-1:0] exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c_en, input logic c_rd, input logic c_wr,
                         input logic [ADDR_W-1:0] c_addr, input logic [DATA_W-1:0] c_wd,
                         input logic d_req, input logic d_we,
                         input logic [ADDR_W-1:0] d_addr, input logic [DATA_W-1:0] d_wd);
        cpu_en = c_en; cpu_rd = c_rd; cpu_wr = c_wr; cpu_addr = c_addr; cpu_wdata = c_wd;
        dma_req = d_req; dma_we = d_we; dma_addr = d_addr; dma_wdata = d_wd;
    endtask

    task automatic drive_idle();
        drive(0, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic preset(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        sram[a]    = d;
        ref_mem[a] = d;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_ = 1'b0;
        drive(1, 1, 0, 12'h100, 8'h00, 1, 0, 12'h200, 8'h00);
        #4;
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 12'h100 || mem_rd !== 1'b1) begin
            n_err++; $display("FAIL reset_mux: mem_en=%b addr=%h rd=%b want 1/100/1", mem_en, mem_addr, mem_rd); end
        n_checks++; if (cpu_stall !== 1'b0 || dma_gnt !== 1'b0) begin
            n_err++; $display("FAIL reset_grant: cpu_stall=%b dma_gnt=%b want 0/0", cpu_stall, dma_gnt); end
        n_checks++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0 || cpu_rdata !== '0 || dma_rdata !== '0) begin
            n_err++; $display("FAIL reset_rvalid: cpu_rv=%b dma_rv=%b cpu_rd=%h dma_rd=%h want 0", cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata); end
        tick(); tick();
        reset_ = 1'b1;
        #3;
        n_checks++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin
            n_err++; $display("FAIL reset_release_rv: cpu_rv=%b dma_rv=%b want 0/0", cpu_rvalid, dma_rvalid); end
        n_checks++; if (dut.starve_cnt !== 4'd0) begin
            n_err++; $display("FAIL reset_starve: cnt=%0d want 0", dut.starve_cnt); end
        tick();
        drive_idle();
        #3;
        n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== ref_mem[12'h100]) begin
            n_err++; $display("FAIL reset_first_read: rv=%b data=%h want 1/%h", cpu_rvalid, cpu_rdata, ref_mem[12'h100]); end
        tick(); tick();
    endtask

    task automatic test_cpu_read();
        preset(12'h123, 8'h5A);
        drive(1, 1, 0, 12'h123, 8'h00, 0, 0, '0, '0);
        #3;
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 12'h123 || mem_rd !== 1'b1 || mem_wr !== 1'b0 || cpu_stall !== 1'b0) begin
            n_err++; $display("FAIL cpu_read_issue: en=%b addr=%h rd=%b wr=%b stall=%b want 1/123/1/0/0", mem_en, mem_addr, mem_rd, mem_wr, cpu_stall); end
        tick();
        drive_idle();
        #3;
        n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h5A || dma_rvalid !== 1'b0 || dma_rdata !== '0) begin
            n_err++; $display("FAIL cpu_read_return: cpu_rv=%b data=%h dma_rv=%b want 1/5a/0", cpu_rvalid, cpu_rdata, dma_rvalid); end
        tick();
    endtask

    task automatic test_conflict();
        preset(12'h020, 8'h3C);
        drive(1, 0, 1, 12'h010, 8'h77, 1, 0, 12'h020, 8'h00);
        ref_mem[12'h010] = 8'h77;
        #3;
        n_checks++; if (cpu_stall !== 1'b0 || dma_gnt !== 1'b0 || mem_wr !== 1'b1 || mem_rd !== 1'b0 ||
                        mem_addr !== 12'h010 || mem_wdata !== 8'h77) begin
            n_err++; $display("FAIL conflict_cpu: stall=%b gnt=%b wr=%b rd=%b addr=%h wd=%h want 0/0/1/0/010/77",
                              cpu_stall, dma_gnt, mem_wr, mem_rd, mem_addr, mem_wdata); end
        tick();
        drive(0, 0, 0, '0, '0, 1, 0, 12'h020, 8'h00);
        #3;
        n_checks++; if (dma_gnt !== 1'b1 || mem_addr !== 12'h020 || mem_rd !== 1'b1 || cpu_rvalid !== 1'b0) begin
            n_err++; $display("FAIL conflict_dma: gnt=%b addr=%h rd=%b cpu_rv=%b want 1/020/1/0", dma_gnt, mem_addr, mem_rd, cpu_rvalid); end
        n_checks++; if (sram[12'h010] !== 8'h77) begin
            n_err++; $display("FAIL conflict_write: mem[010]=%h want 77", sram[12'h010]); end
        tick();
        drive_idle();
        #3;
        n_checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== 8'h3C || cpu_rvalid !== 1'b0) begin
            n_err++; $display("FAIL conflict_return: dma_rv=%b data=%h cpu_rv=%b want 1/3c/0", dma_rvalid, dma_rdata, cpu_rvalid); end
        tick();
    endtask

    task automatic test_starvation();
        ref_mem[12'h040] = 8'hA5;
        for (int c = 1; c <= STARVE_LIMIT + 1; c++) begin
            drive(1, 1, 0, 12'(12'h300 + c), 8'h00, 1, 1, 12'h040, 8'hA5);
            #3;
            n_checks++; if (dma_gnt !== (c == STARVE_LIMIT + 1) || cpu_stall !== (c == STARVE_LIMIT + 1)) begin
                n_err++; $display("FAIL starve_cycle%0d: gnt=%b stall=%b want %b/%b", c, dma_gnt, cpu_stall,
                                  c == STARVE_LIMIT + 1, c == STARVE_LIMIT + 1); end
            tick();
        end
        // CPU keeps its stalled read; DMA is done
        drive(1, 1, 0, 12'(12'h300 + STARVE_LIMIT + 1), 8'h00, 0, 0, '0, '0);
        #3;
        n_checks++; if (dut.starve_cnt !== 4'd0 || cpu_stall !== 1'b0 || cpu_rvalid !== 1'b0) begin
            n_err++; $display("FAIL starve_after: cnt=%0d stall=%b cpu_rv=%b want 0/0/0", dut.starve_cnt, cpu_stall, cpu_rvalid); end
        n_checks++; if (sram[12'h040] !== 8'hA5) begin
            n_err++; $display("FAIL starve_write: mem[040]=%h want a5", sram[12'h040]); end
        tick();
        drive_idle();
        tick();
    endtask

    task automatic test_interleaved();
        preset(12'h001, 8'h11);
        preset(12'h002, 8'h22);
        drive(1, 1, 0, 12'h001, 8'h00, 0, 0, '0, '0);
        tick();
        drive(0, 0, 0, '0, '0, 1, 0, 12'h002, 8'h00);
        #3;
        n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h11 || dma_rvalid !== 1'b0 || dma_gnt !== 1'b1) begin
            n_err++; $display("FAIL inter_cpu: cpu_rv=%b data=%h dma_rv=%b gnt=%b want 1/11/0/1", cpu_rvalid, cpu_rdata, dma_rvalid, dma_gnt); end
        tick();
        drive_idle();
        #3;
        n_checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== 8'h22 || cpu_rvalid !== 1'b0 || cpu_rdata !== '0) begin
            n_err++; $display("FAIL inter_dma: dma_rv=%b data=%h cpu_rv=%b cpu_data=%h want 1/22/0/00", dma_rvalid, dma_rdata, cpu_rvalid, cpu_rdata); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        drive(0, 0, 0, '0, '0, 1, 0, 12'h002, 8'h00);
        tick();
        drive_idle();
        reset_ = 1'b0;
        #3;
        n_checks++; if (dma_rvalid !== 1'b0 || dma_rdata !== '0) begin
            n_err++; $display("FAIL midread_reset: dma_rv=%b data=%h want 0/00", dma_rvalid, dma_rdata); end
        tick();
        reset_ = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #3;
            n_checks++; if (dma_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin
                n_err++; $display("FAIL midread_after%0d: dma_rv=%b cpu_rv=%b want 0/0", c, dma_rvalid, cpu_rvalid); end
            tick();
        end
    endtask

    // Randomized traffic against a rule-level model: the DMA wins whenever the
    // CPU is idle or it has already been refused STARVE_LIMIT cycles in a row.
    task automatic test_random();
        int  denied = 0;
        bit  cpu_hold = 0, dma_hold = 0;
        bit  creq, dwin, cwin;
        logic [W-1:0] ret;
        bit  has_ret;
        logic [DATA_W-1:0] e_cpu_rd, e_dma_rd;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd;
        bit  e_rd, e_wr;
        exp_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!cpu_hold) begin
                cpu_en    = ($urandom_range(0, 9) < 7);
                cpu_rd    = 1'($urandom);
                cpu_wr    = 1'($urandom);
                cpu_addr  = 12'($urandom_range(0, 63));
                cpu_wdata = 8'($urandom);
            end
            if (!dma_hold) begin
                dma_req   = 1'($urandom);
                dma_we    = 1'($urandom);
                dma_addr  = 12'($urandom_range(0, 63));
                dma_wdata = 8'($urandom);
            end
            creq = cpu_en && (cpu_rd || cpu_wr);
            dwin = dma_req && (!creq || denied >= STARVE_LIMIT);
            cwin = creq && !dwin;
            e_addr = dwin ? dma_addr : (cwin ? cpu_addr : '0);
            e_wd   = dwin ? dma_wdata : (cwin ? cpu_wdata : '0);
            e_wr   = dwin ? dma_we : (cwin && cpu_wr);
            e_rd   = dwin ? !dma_we : (cwin && cpu_rd && !cpu_wr);
            has_ret = (exp_q.size() > 0);
            ret = has_ret ? exp_q.pop_front() : '0;
            e_cpu_rd = (has_ret && !ret[DATA_W]) ? ret[DATA_W-1:0] : '0;
            e_dma_rd = (has_ret &&  ret[DATA_W]) ? ret[DATA_W-1:0] : '0;
            #3;
            n_checks++; if (cpu_stall !== (creq && !cwin) || dma_gnt !== dwin) begin
                n_err++; $display("FAIL rand_grant cyc%0d: stall=%b gnt=%b want %b/%b", cyc, cpu_stall, dma_gnt, creq && !cwin, dwin); end
            n_checks++; if (mem_en !== (cwin || dwin) || mem_rd !== e_rd || mem_wr !== e_wr ||
                            mem_addr !== e_addr || mem_wdata !== e_wd) begin
                n_err++; $display("FAIL rand_mem cyc%0d: en=%b rd=%b wr=%b addr=%h wd=%h want %b/%b/%b/%h/%h",
                                  cyc, mem_en, mem_rd, mem_wr, mem_addr, mem_wdata, cwin || dwin, e_rd, e_wr, e_addr, e_wd); end
            n_checks++; if (cpu_rvalid !== (has_ret && !ret[DATA_W]) || dma_rvalid !== (has_ret && ret[DATA_W]) ||
                            cpu_rdata !== e_cpu_rd || dma_rdata !== e_dma_rd) begin
                n_err++; $display("FAIL rand_return cyc%0d: cpu_rv=%b %h dma_rv=%b %h want %b %h / %b %h", cyc,
                                  cpu_rvalid, cpu_rdata, dma_rvalid, dma_rdata,
                                  has_ret && !ret[DATA_W], e_cpu_rd, has_ret && ret[DATA_W], e_dma_rd); end
            if (e_wr) ref_mem[e_addr] = e_wd;
            if (e_rd) exp_q.push_back({dwin, ref_mem[e_addr]});
            denied   = (dma_req && !dwin) ? ((denied + 1 > STARVE_LIMIT) ? STARVE_LIMIT : denied + 1) : 0;
            cpu_hold = creq && !cwin;
            dma_hold = dma_req && !dwin;
            tick();
        end
        drive_idle();
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            logic [DATA_W-1:0] v;
            v = 8'($urandom);
            sram[i]    = v;
            ref_mem[i] = v;
        end
        mem_rdata = '0;
        test_reset();
        test_cpu_read();
        test_conflict();
        test_starvation();
        test_interleaved();
        test_reset_mid_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
